// File: rtl/scan_chain_pkg.sv
// Shared constants for the scan-chain responder: FSM encoding, CRC polynomial,
// frame length width and the single-bit CRC-8 update used when SCAN_TARGET_CRC_EN is set.
package scan_chain_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [7:0] CRC8_POLY   = 8'h07;
  localparam int         FRAME_LEN_W = 8;

  // MSB-first CRC-8 step, one serial bit per call
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/sc_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, plus a rising-edge pulse
// derived from the synchronised level.
module sc_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // synchroniser chain and previous-level register for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = sync_r[STAGES-1] & ~prev_r;

endmodule

// File: rtl/scan_chain_target.sv
// Scan-chain responder: shifts the master's serial stream through a CHAIN_LEN register
// and captures it when sc_clk goes quiet. Optional CRC-8 under `SCAN_TARGET_CRC_EN.
module scan_chain_target
  import scan_chain_pkg::*;
#(
  parameter int CHAIN_LEN    = 100,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                   clki,
  input  logic                   reset_n,
  input  logic                   sc_clk,
  input  logic                   sc_data,
  output logic                   s_chipout,
  input  logic                   preload_en,
  input  logic [CHAIN_LEN-1:0]   preload_data,
  output logic [CHAIN_LEN-1:0]   capture_data,
  output logic                   capture_valid,
  output logic [FRAME_LEN_W-1:0] frame_len,
  output logic                   overflow,
  output logic [7:0]             crc_out
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [FRAME_LEN_W-1:0] LEN_SAT   = FRAME_LEN_W'(CHAIN_LEN + 1);
  localparam logic [FRAME_LEN_W-1:0] LEN_LIMIT = FRAME_LEN_W'(CHAIN_LEN);
  localparam logic [IDLE_W-1:0]      IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  logic                   sc_edge_s;
  logic                   sc_data_s;
  logic                   sc_clk_level_unused;
  logic                   sc_data_rise_unused;
  logic                   frame_end_s;
  logic [1:0]             state_r;
  logic [FRAME_LEN_W-1:0] bit_cnt_r;
  logic [IDLE_W-1:0]      idle_cnt_r;
  logic [CHAIN_LEN-1:0]   shift_reg_r;

  sc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk   (clki),
    .rst_n (reset_n),
    .din   (sc_clk),
    .level (sc_clk_level_unused),
    .rise  (sc_edge_s)
  );

  sc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk   (clki),
    .rst_n (reset_n),
    .din   (sc_data),
    .level (sc_data_s),
    .rise  (sc_data_rise_unused)
  );

  // an edge in the timeout cycle keeps the frame open
  assign frame_end_s = (state_r == ST_SHIFT) && !sc_edge_s && (idle_cnt_r == IDLE_LAST);

  // frame FSM with edge and idle counters
  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= '0;
      idle_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sc_edge_s) begin
            state_r    <= ST_SHIFT;
            bit_cnt_r  <= FRAME_LEN_W'(1);
            idle_cnt_r <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (sc_edge_s) begin
            idle_cnt_r <= '0;
            if (bit_cnt_r != LEN_SAT) begin
              bit_cnt_r <= bit_cnt_r + FRAME_LEN_W'(1);
            end else begin
              bit_cnt_r <= bit_cnt_r;
            end
          end else if (frame_end_s) begin
            state_r <= ST_DONE;
          end else begin
            idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          bit_cnt_r  <= '0;
          idle_cnt_r <= '0;
        end
        default: begin
          state_r    <= ST_IDLE;
          bit_cnt_r  <= '0;
          idle_cnt_r <= '0;
        end
      endcase
    end
  end

  // scan register, preload in IDLE only (an edge wins), and registered serial output
  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg_r <= '0;
      s_chipout   <= 1'b0;
    end else begin
      if (sc_edge_s) begin
        shift_reg_r <= {shift_reg_r[CHAIN_LEN-2:0], sc_data_s};
      end else if (preload_en && (state_r == ST_IDLE)) begin
        shift_reg_r <= preload_data;
      end else begin
        shift_reg_r <= shift_reg_r;
      end
      s_chipout <= shift_reg_r[CHAIN_LEN-1];
    end
  end

  // capture registers load as the FSM enters DONE so data and the valid pulse line up
  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      capture_data  <= '0;
      frame_len     <= '0;
      overflow      <= 1'b0;
      capture_valid <= 1'b0;
    end else begin
      capture_valid <= frame_end_s;
      if (frame_end_s) begin
        capture_data <= shift_reg_r;
        frame_len    <= bit_cnt_r;
        overflow     <= (bit_cnt_r > LEN_LIMIT);
      end else begin
        capture_data <= capture_data;
        frame_len    <= frame_len;
        overflow     <= overflow;
      end
    end
  end

`ifdef SCAN_TARGET_CRC_EN
  logic [7:0] crc_r;

  // running CRC over every edge of the frame, cleared on the way back to IDLE
  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      crc_r   <= 8'h00;
      crc_out <= 8'h00;
    end else begin
      if (state_r == ST_DONE) begin
        crc_r <= 8'h00;
      end else if (sc_edge_s) begin
        crc_r <= crc8_step(crc_r, sc_data_s);
      end else begin
        crc_r <= crc_r;
      end
      if (frame_end_s) begin
        crc_out <= crc_r;
      end else begin
        crc_out <= crc_out;
      end
    end
  end
`else
  assign crc_out = 8'h00;
`endif

endmodule

// File: tb/tb_scan_chain_target.sv
// Randomised scoreboard bench for scan_chain_target; honours SCAN_TARGET_CRC_EN for crc_out.
module tb_scan_chain_target;

  localparam int CL = 100;
  localparam int SS = 2;
  localparam int IT = 1024;

  logic          clki = 1'b0;
  logic          reset_n = 1'b0;
  logic          sc_clk = 1'b0;
  logic          sc_data = 1'b0;
  logic          s_chipout;
  logic          preload_en = 1'b0;
  logic [CL-1:0] preload_data = '0;
  logic [CL-1:0] capture_data;
  logic          capture_valid;
  logic [7:0]    frame_len;
  logic          overflow;
  logic [7:0]    crc_out;

  scan_chain_target #(.CHAIN_LEN(CL), .SYNC_STAGES(SS), .IDLE_TIMEOUT(IT)) dut (
    .clki          (clki),
    .reset_n       (reset_n),
    .sc_clk        (sc_clk),
    .sc_data       (sc_data),
    .s_chipout     (s_chipout),
    .preload_en    (preload_en),
    .preload_data  (preload_data),
    .capture_data  (capture_data),
    .capture_valid (capture_valid),
    .frame_len     (frame_len),
    .overflow      (overflow),
    .crc_out       (crc_out)
  );

  always #5 clki = ~clki;

  int unsigned cyc = 0;
  always @(posedge clki) cyc <= cyc + 1;

  typedef struct {
    logic [CL-1:0] data;
    int            len;
    bit            ovf;
    logic [7:0]    crc;
    int unsigned   at;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            passed = 0;
  logic [CL-1:0] model_chain = '0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endfunction

  // register contents after k bits of b arrived on top of old: newest bit at position 0
  function automatic logic [CL-1:0] chain_view(logic [CL-1:0] old, bit b[$], int k);
    logic [CL-1:0] v;
    for (int i = 0; i < CL; i++) v[i] = (i < k) ? b[k-1-i] : old[i-k];
    return v;
  endfunction

  // CRC as remainder of M(x)*x^8 divided by x^8+x^2+x+1, by long division
  function automatic logic [7:0] model_crc(bit b[$]);
    logic [7:0] r;
    r = 8'h00;
`ifdef SCAN_TARGET_CRC_EN
    begin
      bit         a[$];
      logic [8:0] p;
      p = 9'h107;
      a = b;
      for (int j = 0; j < 8; j++) a.push_back(1'b0);
      for (int i = 0; i < b.size(); i++)
        if (a[i]) for (int j = 0; j < 9; j++) a[i+j] = a[i+j] ^ p[8-j];
      for (int j = 0; j < 8; j++) r[7-j] = a[b.size()+j];
    end
`endif
    return r;
  endfunction

  // mode 0: 1,0,1,0..  1: all zero  2: random  3: seven zeros then one
  task automatic send_frame(input int n, input int half, input int mode, input bit expect_cap);
    bit            bits[$];
    logic [CL-1:0] start;
    int unsigned   last_c;
    bit            b;
    exp_t          e;
    start  = model_chain;
    last_c = 0;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: b = (i % 2 == 0);
        1: b = 1'b0;
        3: b = (i == 7);
        default: b = 1'($urandom_range(0, 1));
      endcase
      sc_data = b;
      repeat (half) @(negedge clki);
      sc_clk = 1'b1;
      last_c = cyc;
      bits.push_back(b);
      model_chain = chain_view(start, bits, bits.size());
      repeat (half) @(negedge clki);
      sc_clk = 1'b0;
      check("chipout", 128'(s_chipout), 128'(model_chain[CL-1]));
    end
    if (expect_cap) begin
      e.data = model_chain;
      e.len  = (n > CL) ? CL + 1 : n;
      e.ovf  = (n > CL);
      e.crc  = model_crc(bits);
      e.at   = last_c + SS + IT + 1;
      sb.push_back(e);
      repeat (IT + 20) @(negedge clki);
    end
  endtask

  task automatic check_reset_state();
    check("rst_capture_data", 128'(capture_data), 128'(0));
    check("rst_capture_valid", 128'(capture_valid), 128'(0));
    check("rst_frame_len", 128'(frame_len), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_crc_out", 128'(crc_out), 128'(0));
    check("rst_chipout", 128'(s_chipout), 128'(0));
  endtask

  // monitor: every capture_valid pulse must match the oldest expected frame
  always @(negedge clki) begin
    if (reset_n && capture_valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_capture actual=pulse at cycle %0d required=no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("capture_data", 128'(capture_data), 128'(e.data));
        check("frame_len", 128'(frame_len), 128'(e.len));
        check("overflow", 128'(overflow), 128'(e.ovf));
        check("crc_out", 128'(crc_out), 128'(e.crc));
        check("capture_cycle", 128'(cyc), 128'(e.at));
      end
    end
  end

  initial begin
    repeat (5) @(negedge clki);
    check_reset_state();
    reset_n = 1'b1;
    model_chain = '0;
    repeat (5) @(negedge clki);

    send_frame(100, 20, 0, 1'b1);

    preload_data = '0;
    preload_data[0] = 1'b1;
    preload_en = 1'b1;
    @(negedge clki);
    preload_en = 1'b0;
    model_chain = preload_data;
    repeat (4) @(negedge clki);
    check("preload_chipout", 128'(s_chipout), 128'(model_chain[CL-1]));
    send_frame(100, 8, 1, 1'b1);

    send_frame(40, 8, 2, 1'b1);
    send_frame(105, 8, 2, 1'b1);
    send_frame(100, 8, 2, 1'b1);

    send_frame(50, 8, 2, 1'b0);
    repeat (3) @(negedge clki);
    reset_n = 1'b0;
    @(negedge clki);
    check_reset_state();
    reset_n = 1'b1;
    model_chain = '0;
    repeat (IT + 20) @(negedge clki);
    send_frame(100, 8, 2, 1'b1);

    send_frame(8, 8, 3, 1'b1);
    send_frame(23, 8, 2, 1'b1);

    for (int k = 0; k < 3000 && sb.size() > 0; k++) @(negedge clki);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL capture_timeout actual=%0d frames pending required=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
